// File: rtl/l2_request_sequencer.sv
// l2_request_sequencer
//   Front end of the L2 lookup/update engine.
//   - Takes L1 demand misses, splits the address into tag/index/offset and runs
//     one L2 find_start/updated handshake per lookup. The hit/miss result goes back to L1.
//   - Passes L2 back-invalidation notices to L1 with the offset bits cleared.
//   - A demand miss queues a next-line prefetch. Queued prefetches go to L2 only
//     when no demand is waiting.
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   demand_valid/addr/ready     L1 miss request (ready is high only in IDLE)
//   resp_valid/hit/addr         one-cycle demand result
//   l2_tag/index/block_offset   split lookup address, stable from ISSUE to RESP
//   l2_find_start               one-cycle lookup strobe
//   l2_found/updated            L2 result and update-complete pulse
//   l2_back_invalidation(_data) L2 eviction notice and evicted address
//   binv_valid/addr             one-cycle invalidation forwarded to L1
//   *_count                     16-bit saturating statistics counters
module l2_request_sequencer #(
    parameter int unsigned BLOCK_SIZE_BYTE = 16,
    parameter int unsigned SET_SIZE        = 512,
    parameter bit          PF_ENABLE       = 1'b1,
    parameter int unsigned PF_DEPTH        = 4,
    localparam int unsigned OFFW = $clog2(BLOCK_SIZE_BYTE),
    localparam int unsigned IDXW = $clog2(SET_SIZE),
    localparam int unsigned TAGW = 32 - IDXW - OFFW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            demand_valid,
    input  logic [31:0]     demand_addr,
    output logic            demand_ready,
    output logic            resp_valid,
    output logic            resp_hit,
    output logic [31:0]     resp_addr,
    output logic [TAGW-1:0] l2_tag,
    output logic [IDXW-1:0] l2_index,
    output logic [OFFW-1:0] l2_block_offset,
    output logic            l2_find_start,
    input  logic            l2_found,
    input  logic            l2_updated,
    input  logic            l2_back_invalidation,
    input  logic [31:0]     l2_back_invalidation_data,
    output logic            binv_valid,
    output logic [31:0]     binv_addr,
    output logic [15:0]     demand_count,
    output logic [15:0]     demand_hit_count,
    output logic [15:0]     pf_issue_count,
    output logic [15:0]     pf_drop_count
);

    localparam int unsigned   LINEW     = 32 - OFFW;
    localparam int unsigned   PTRW      = $clog2(PF_DEPTH);
    localparam logic [PTRW:0] FIFO_FULL = (PTRW + 1)'(PF_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitUpd, StResp} state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             is_pf_q, is_pf_d;
    logic             hit_q, hit_d;
    logic             binv_pend_q, binv_pend_d;
    logic [LINEW-1:0] binv_line_q, binv_line_d;
    logic             ready_q, ready_d;
    logic             find_start_q, find_start_d;

    // Prefetch FIFO holds line addresses (offset bits dropped).
    logic [LINEW-1:0] fifo_q [PF_DEPTH];
    logic [LINEW-1:0] fifo_d [PF_DEPTH];
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW:0]    fifo_cnt_q, fifo_cnt_d;

    logic [15:0] demand_count_q, demand_count_d;
    logic [15:0] demand_hit_count_q, demand_hit_count_d;
    logic [15:0] pf_issue_count_q, pf_issue_count_d;
    logic [15:0] pf_drop_count_q, pf_drop_count_d;

    logic [LINEW-1:0] cur_line, next_line;
    logic             last_line, dup_hit, fifo_empty, fifo_full;
    logic             idle_go, pop, push_req, push, drop;
    logic             unused_binv_offset;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    assign unused_binv_offset = ^l2_back_invalidation_data[OFFW-1:0];

    assign cur_line   = addr_q[31:OFFW];
    assign next_line  = cur_line + LINEW'(1);
    assign last_line  = &cur_line;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_FULL);

    // ready_q is low on the first cycle out of reset, so nothing is accepted then.
    assign idle_go = (state_q == StIdle) && ready_q;
    assign pop     = idle_go && !demand_valid && !fifo_empty;

    // An entry is live if its distance from the read pointer is below the fill count.
    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned i = 0; i < PF_DEPTH; i++) begin
            if (({1'b0, PTRW'(PTRW'(i) - rd_ptr_q)} < fifo_cnt_q) && (fifo_q[i] == next_line)) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Only a demand miss may push a prefetch, so prefetches never chain.
    assign push_req = PF_ENABLE && (state_q == StResp) && !is_pf_q && !hit_q &&
                      !last_line && !dup_hit;
    assign push     = push_req && !fifo_full;
    assign drop     = push_req && fifo_full;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        is_pf_d     = is_pf_q;
        hit_d       = hit_q;
        binv_pend_d = binv_pend_q;
        binv_line_d = binv_line_q;
        unique case (state_q)
            StIdle: begin
                if (idle_go && demand_valid) begin
                    addr_d  = demand_addr;
                    is_pf_d = 1'b0;
                    state_d = StIssue;
                end else if (pop) begin
                    addr_d  = {fifo_q[rd_ptr_q], {OFFW{1'b0}}};
                    is_pf_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWaitUpd;
            StWaitUpd: begin
                if (l2_back_invalidation) begin
                    binv_pend_d = 1'b1;
                    binv_line_d = l2_back_invalidation_data[31:OFFW];
                end
                if (l2_updated) begin
                    hit_d   = l2_found;
                    state_d = StResp;
                end
            end
            StResp: begin
                binv_pend_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
        ready_d      = (state_d == StIdle);
        find_start_d = (state_d == StIssue);
    end

    // Pop only happens in IDLE and push only in RESP, so they never overlap.
    always_comb begin
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTRW'(1);
            fifo_cnt_d = fifo_cnt_q - (PTRW + 1)'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = next_line;
            wr_ptr_d         = wr_ptr_q + PTRW'(1);
            fifo_cnt_d       = fifo_cnt_q + (PTRW + 1)'(1);
        end
    end

    always_comb begin
        demand_count_d     = sat_inc(demand_count_q, (state_q == StResp) && !is_pf_q);
        demand_hit_count_d = sat_inc(demand_hit_count_q, (state_q == StResp) && !is_pf_q && hit_q);
        pf_issue_count_d   = sat_inc(pf_issue_count_q, (state_q == StIssue) && is_pf_q);
        pf_drop_count_d    = sat_inc(pf_drop_count_q, drop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q            <= StIdle;
            addr_q             <= '0;
            is_pf_q            <= 1'b0;
            hit_q              <= 1'b0;
            binv_pend_q        <= 1'b0;
            binv_line_q        <= '0;
            ready_q            <= 1'b0;
            find_start_q       <= 1'b0;
            for (int unsigned i = 0; i < PF_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            fifo_cnt_q         <= '0;
            demand_count_q     <= '0;
            demand_hit_count_q <= '0;
            pf_issue_count_q   <= '0;
            pf_drop_count_q    <= '0;
        end else begin
            state_q            <= state_d;
            addr_q             <= addr_d;
            is_pf_q            <= is_pf_d;
            hit_q              <= hit_d;
            binv_pend_q        <= binv_pend_d;
            binv_line_q        <= binv_line_d;
            ready_q            <= ready_d;
            find_start_q       <= find_start_d;
            fifo_q             <= fifo_d;
            rd_ptr_q           <= rd_ptr_d;
            wr_ptr_q           <= wr_ptr_d;
            fifo_cnt_q         <= fifo_cnt_d;
            demand_count_q     <= demand_count_d;
            demand_hit_count_q <= demand_hit_count_d;
            pf_issue_count_q   <= pf_issue_count_d;
            pf_drop_count_q    <= pf_drop_count_d;
        end
    end

    always_comb begin
        demand_ready     = ready_q;
        l2_find_start    = find_start_q;
        l2_tag           = addr_q[31:IDXW+OFFW];
        l2_index         = addr_q[IDXW+OFFW-1:OFFW];
        l2_block_offset  = addr_q[OFFW-1:0];
        resp_valid       = (state_q == StResp) && !is_pf_q;
        resp_hit         = resp_valid && hit_q;
        resp_addr        = resp_valid ? addr_q : '0;
        binv_valid       = (state_q == StResp) && binv_pend_q;
        binv_addr        = binv_valid ? {binv_line_q, {OFFW{1'b0}}} : '0;
        demand_count     = demand_count_q;
        demand_hit_count = demand_hit_count_q;
        pf_issue_count   = pf_issue_count_q;
        pf_drop_count    = pf_drop_count_q;
    end

endmodule

// File: doc/l2_request_sequencer.md
Name: l2_request_sequencer

Overview:
- Sits directly upstream of the L2 cache lookup/update engine.
- Accepts L1 demand-miss addresses, splits each into tag/index/offset, and runs the L2 find_start/updated handshake. Returns hit/miss to L1.
- Forwards L2 back-invalidation notices to L1.
- On a demand miss, queues a next-line prefetch. Queued prefetches are issued to L2 whenever no demand is pending.

Parameters:
- BLOCK_SIZE_BYTE, 16, line size in bytes; OFFW = log2 = 4.
- SET_SIZE, 512, L2 sets; IDXW = log2 = 9; TAGW = 32-IDXW-OFFW = 19.
- PF_ENABLE, 1, 1 = next-line prefetch on demand miss.
- PF_DEPTH, 4, prefetch FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- demand_valid  in  1  L1 miss request valid
- demand_addr  in  32  byte address of request
- demand_ready  out  1  high only in IDLE
- resp_valid  out  1  one-cycle pulse, demand result
- resp_hit  out  1  1 = found in L2
- resp_addr  out  32  echoed demand_addr
- l2_tag  out  TAGW  addr[31:IDXW+OFFW], held stable from ISSUE until RESP
- l2_index  out  IDXW  addr[IDXW+OFFW-1:OFFW]
- l2_block_offset  out  OFFW  addr[OFFW-1:0]
- l2_find_start  out  1  registered, high exactly one cycle per lookup
- l2_found  in  1  L2 found_in_cache
- l2_updated  in  1  L2 update-complete pulse
- l2_back_invalidation  in  1  L2 eviction notice
- l2_back_invalidation_data  in  32  evicted line address
- binv_valid  out  1  one-cycle pulse to L1
- binv_addr  out  32  address to invalidate, offset bits forced to 0
- demand_count, demand_hit_count, pf_issue_count, pf_drop_count  out  16 each  saturating counters

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; FIFO emptied; all outputs and counters 0. demand_ready becomes 1 on the first cycle after reset deasserts. Reset mid-lookup abandons the transaction; no resp_valid or binv_valid is produced for it.
- FSM: IDLE → ISSUE → WAIT_UPD → RESP → IDLE.
- IDLE: demand_ready=1.
  - If demand_valid, latch demand_addr with is_pf=0 and go to ISSUE.
  - Else if the FIFO is non-empty, pop the head, latch it with is_pf=1, and go to ISSUE.
  - Demand always beats prefetch.
- ISSUE: l2_find_start=1 for this single cycle. l2_tag/index/offset are driven from the latched address. Go to WAIT_UPD.
- WAIT_UPD: l2_find_start=0.
  - If l2_back_invalidation is high in any cycle, latch {l2_back_invalidation_data[31:OFFW], 0}.
  - When l2_updated==1, sample l2_found into the hit flag and go to RESP.
  - There is no timeout. Hit latency depends on the L2 hit way.
- RESP (1 cycle): go to IDLE.
  - If is_pf=0: resp_valid=1, resp_hit=hit flag, resp_addr=latched address.
  - If a back-invalidation was latched: binv_valid=1. It fires for prefetch lookups too.
  - This cycle guarantees L2 has returned to its idle state before the next l2_find_start.
- Minimum spacing between l2_find_start pulses is governed by l2_updated, never less than 4 cycles.
- Prefetch push: happens at the RESP edge of a demand miss when PF_ENABLE=1.
  - Pushed address: next = {addr[31:OFFW]+1, OFFW'b0}.
  - No push if addr[31:OFFW] is all ones (no wrap to 0).
  - No push if next equals any valid FIFO entry (duplicate filter).
  - If the FIFO is full, drop the new entry and increment pf_drop_count.
  - Pushes never occur on a prefetch lookup (degree 1, no chaining).
- Counters (saturate at 16'hFFFF, never wrap):
  - demand_count: +1 per demand RESP.
  - demand_hit_count: +1 per demand RESP with hit.
  - pf_issue_count: +1 per prefetch ISSUE.
- FIFO pop and push never coincide: pop happens in IDLE, push in RESP.

Test Plan:
- Reset held low for 3 cycles mid-WAIT_UPD → all outputs 0. After release, demand_ready=1 and the FIFO is empty; no resp_valid.
- demand_addr=0x0000_1234, L2 model miss with l2_updated 4 cycles after find_start → split correct: tag=0x00000, index=0x123, offset=0x4.
  - resp_valid pulse with resp_hit=0 and resp_addr=0x0000_1234.
  - Prefetch 0x0000_1240 is then issued: pf_issue_count=1.
  - demand_count=1, demand_hit_count=0.
- Demand arriving while a prefetch is queued → demand is issued first; the prefetch is issued after the demand's RESP.
- Five consecutive distinct misses with the L2 model stalled on prefetches (PF_DEPTH=4) → pf_drop_count=1. Repeating a miss to 0x100 twice pushes 0x110 only once.
- Demand 0xFFFF_FFF8 miss → no prefetch pushed; FIFO stays empty.
- L2 model raises l2_back_invalidation with data 0xABCD_E125 during lookup → binv_valid pulses in RESP with binv_addr=0xABCD_E120. Counters saturate: preload demand_count to 0xFFFF, then one more demand leaves it at 0xFFFF.
